// File: rtl/fp_accum_seq.sv
// Packet accumulator that sequences each term through an external pipelined FpAdd.
// Only one add is in flight at a time; the packet total and term count are emitted with a valid/ready handshake.
module fp_accum_seq #(
    parameter int ADD_LAT = 2,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [26:0]      in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [26:0]      add_in1,
    output logic [26:0]      add_in2,
    input  logic [26:0]      add_sum,
    output logic [26:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIRST = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int WCNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        r_state;
    logic [26:0]       r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_lastq;
    logic [26:0]       r_addIn1;
    logic [26:0]       r_addIn2;
    logic [26:0]       r_outSum;
    logic [CNT_W-1:0]  r_outCount;
    logic              r_outValid;

    logic              w_inReady;
    logic              w_accept;
    logic              w_firstAccept;
    logic              w_termAccept;
    logic              w_addDone;
    logic              w_outFire;
    logic [CNT_W-1:0]  w_cntNext;

    // Reset gates in_ready so nothing is taken while the block is being cleared.
    assign w_inReady     = !rst && ((r_state == S_IDLE) || (r_state == S_FIRST));
    assign w_accept      = in_valid && w_inReady;
    assign w_firstAccept = w_accept && (r_state == S_IDLE);
    assign w_termAccept  = w_accept && (r_state == S_FIRST);
    assign w_addDone     = (r_state == S_WAIT) && (r_wcnt == WCNT_LAST);
    assign w_outFire     = r_outValid && out_ready;
    assign w_cntNext     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_firstAccept) r_state <= in_last ? S_DONE : S_FIRST;
                S_FIRST: if (w_termAccept)  r_state <= S_WAIT;
                S_WAIT:  if (w_addDone)     r_state <= r_lastq ? S_DONE : S_FIRST;
                S_DONE:  if (w_outFire)     r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The first term seeds the accumulator directly, so a one-term packet is passed through bit-exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 27'h0;
        end else if (w_firstAccept) begin
            r_acc <= in_data;
        end else if (w_addDone) begin
            r_acc <= add_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_firstAccept) begin
            r_cnt <= CNT_W'(1);
        end else if (w_termAccept) begin
            r_cnt <= w_cntNext;
        end else if ((r_state == S_DONE) && w_outFire) begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_lastq <= 1'b0;
        end else if (w_termAccept) begin
            r_wcnt  <= '0;
            r_lastq <= in_last;
        end else if (r_state == S_WAIT) begin
            r_wcnt  <= r_wcnt + 1'b1;
        end
    end

    // Adder operands change only when a new add is issued and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addIn1 <= 27'h0;
            r_addIn2 <= 27'h0;
        end else if (w_termAccept) begin
            r_addIn1 <= r_acc;
            r_addIn2 <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outSum   <= 27'h0;
            r_outCount <= '0;
            r_outValid <= 1'b0;
        end else if ((r_state == S_DONE) && !r_outValid) begin
            r_outSum   <= r_acc;
            r_outCount <= r_cnt;
            r_outValid <= 1'b1;
        end else if (w_outFire) begin
            r_outValid <= 1'b0;
        end
    end

    assign in_ready  = w_inReady;
    assign add_in1   = r_addIn1;
    assign add_in2   = r_addIn2;
    assign out_sum   = r_outSum;
    assign out_count = r_outCount;
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq: table of packets with hand-computed totals, plus
// hand-written sequences for output back-pressure, mid-add reset and counter saturation.
module tb_fp_accum_seq;

    localparam int ADD_LAT = 2;
    localparam int CNT_W   = 10;

    localparam logic [26:0] F_P1 = 27'h1FC0000;
    localparam logic [26:0] F_P2 = 27'h2000000;
    localparam logic [26:0] F_P3 = 27'h2020000;
    localparam logic [26:0] F_P4 = 27'h2040000;
    localparam logic [26:0] F_P6 = 27'h2060000;
    localparam logic [26:0] F_N1 = 27'h5FC0000;
    localparam logic [26:0] F_N3 = 27'h6020000;

    logic             clk;
    logic             rst;
    logic [26:0]      inData;
    logic             inLast;
    logic             inValid;
    logic             inReady;
    logic [26:0]      addIn1;
    logic [26:0]      addIn2;
    logic [26:0]      addSum;
    logic [26:0]      outSum;
    logic [CNT_W-1:0] outCount;
    logic             outValid;
    logic             outReady;

    int total = 0;
    int bad   = 0;

    fp_accum_seq #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (inData),
        .in_last   (inLast),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .add_in1   (addIn1),
        .add_in2   (addIn2),
        .add_sum   (addSum),
        .out_sum   (outSum),
        .out_count (outCount),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FpAdd with ADD_LAT-1 register stages, so the sum is settled at the capture edge.
    function automatic real fp27ToReal(input logic [26:0] v);
        logic [10:0] e11;
        logic [63:0] b;
        if (v[25:18] == 8'd0) return 0.0;
        e11 = {3'b000, v[25:18]} + 11'd896;
        b   = {v[26], e11, v[17:0], 34'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [26:0] realToFp27(input real r);
        logic [63:0] b;
        logic [7:0]  e8;
        if (r == 0.0) return 27'h0;
        b  = $realtobits(r);
        e8 = 8'(b[62:52] - 11'd896);
        return {b[63], e8, b[51:34]};
    endfunction

    always @(posedge clk) addSum <= realToFp27(fp27ToReal(addIn1) + fp27ToReal(addIn2));

    typedef struct {
        int               n;
        logic [2:0][26:0] term;
        logic [2:0][26:0] accBefore;
        logic [26:0]      expSum;
        logic [CNT_W-1:0] expCount;
        logic [26:0]      holdIn1;
        logic [26:0]      holdIn2;
        int               holdCycles;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mkVec(input int n, input logic [26:0] t0, input logic [26:0] t1,
                                   input logic [26:0] t2, input logic [26:0] a1,
                                   input logic [26:0] a2, input logic [26:0] s,
                                   input int c, input logic [26:0] h1,
                                   input logic [26:0] h2, input int hold);
        vec_t v;
        v.n            = n;
        v.term[0]      = t0;
        v.term[1]      = t1;
        v.term[2]      = t2;
        v.accBefore[0] = 27'h0;
        v.accBefore[1] = a1;
        v.accBefore[2] = a2;
        v.expSum       = s;
        v.expCount     = CNT_W'(c);
        v.holdIn1      = h1;
        v.holdIn2      = h2;
        v.holdCycles   = hold;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the first negedge following acceptance.
    task automatic sendTerm(input logic [26:0] d, input logic l);
        int waitCycles;
        waitCycles = 0;
        inData  = d;
        inLast  = l;
        inValid = 1'b1;
        while (inReady !== 1'b1 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("inReadyWait", {31'd0, inReady}, 32'd1);
        @(negedge clk);
        inValid = 1'b0;
        inData  = 27'h7FFFFFF;
    endtask

    task automatic handshake();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("validDropped", {31'd0, outValid}, 32'd0);
        checkOutput("readyAfterHs", {31'd0, inReady}, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int low;
        int lat;
        for (int i = 0; i < v.n; i++) begin
            sendTerm(v.term[i], (i == v.n - 1));
            if (i > 0) begin
                checkOutput("addIn1Issue", {5'd0, addIn1}, {5'd0, v.accBefore[i]});
                checkOutput("addIn2Issue", {5'd0, addIn2}, {5'd0, v.term[i]});
            end
            if (i < v.n - 1) begin
                if (i > 0) begin
                    low = (inReady !== 1'b1) ? 1 : 0;
                    while (inReady !== 1'b1 && low < 20) begin
                        @(negedge clk);
                        if (inReady !== 1'b1) low++;
                    end
                    checkOutput("readyLowCycles", low, ADD_LAT);
                end
            end else begin
                lat = 1;
                while (outValid !== 1'b1 && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                checkOutput("outValidLatency", lat, (v.n == 1) ? 2 : ADD_LAT + 2);
            end
        end
        checkOutput("outSum", {5'd0, outSum}, {5'd0, v.expSum});
        checkOutput("outCount", {22'd0, outCount}, {22'd0, v.expCount});
        if (v.n == 1) begin
            checkOutput("addIn1Held", {5'd0, addIn1}, {5'd0, v.holdIn1});
            checkOutput("addIn2Held", {5'd0, addIn2}, {5'd0, v.holdIn2});
        end
        for (int h = 0; h < v.holdCycles; h++) begin
            @(negedge clk);
            checkOutput("holdValid", {31'd0, outValid}, 32'd1);
            checkOutput("holdSum", {5'd0, outSum}, {5'd0, v.expSum});
            checkOutput("holdReady", {31'd0, inReady}, 32'd0);
        end
        handshake();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        vecs[0] = mkVec(2, F_P1, F_P2, 27'h0, F_P1, 27'h0, F_P3, 2, 27'h0, 27'h0, 0);
        vecs[1] = mkVec(3, F_P1, F_P2, F_P3, F_P1, F_P3, F_P6, 3, 27'h0, 27'h0, 0);
        vecs[2] = mkVec(1, F_N1, 27'h0, 27'h0, 27'h0, 27'h0, F_N1, 1, F_P3, F_P3, 0);
        vecs[3] = mkVec(3, F_P4, F_N1, F_N3, F_P4, F_P3, 27'h0, 3, 27'h0, 27'h0, 10);
        vecs[4] = mkVec(2, F_P2, F_P2, 27'h0, F_P2, 27'h0, F_P4, 2, 27'h0, 27'h0, 0);

        rst      = 1'b1;
        inData   = 27'h0;
        inLast   = 1'b0;
        inValid  = 1'b1;
        outReady = 1'b0;
        @(negedge clk);
        checkOutput("rstInReady", {31'd0, inReady}, 32'd0);
        checkOutput("rstOutValid", {31'd0, outValid}, 32'd0);
        checkOutput("rstOutSum", {5'd0, outSum}, 32'd0);
        checkOutput("rstAddIn1", {5'd0, addIn1}, 32'd0);
        inValid = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        checkOutput("idleInReady", {31'd0, inReady}, 32'd1);
        checkOutput("rstOutCount", {22'd0, outCount}, 32'd0);
        checkOutput("rstAddIn2", {5'd0, addIn2}, 32'd0);

        for (int k = 0; k < 4; k++) applyStimulus(vecs[k]);

        // Reset lands while the second add of an unfinished packet is in flight.
        sendTerm(F_P1, 1'b0);
        sendTerm(F_P2, 1'b0);
        checkOutput("midAddIn2", {5'd0, addIn2}, {5'd0, F_P2});
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstInReady", {31'd0, inReady}, 32'd0);
        checkOutput("midRstValid", {31'd0, outValid}, 32'd0);
        checkOutput("midRstAddIn1", {5'd0, addIn1}, 32'd0);
        checkOutput("midRstAddIn2", {5'd0, addIn2}, 32'd0);
        checkOutput("midRstSum", {5'd0, outSum}, 32'd0);
        checkOutput("midRstCount", {22'd0, outCount}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postRstReady", {31'd0, inReady}, 32'd1);
        checkOutput("postRstValid", {31'd0, outValid}, 32'd0);
        applyStimulus(vecs[4]);

        // 1025 zero terms: the count must stop at 2**CNT_W-1.
        for (int i = 0; i < 1025; i++) sendTerm(27'h0, (i == 1024));
        lat = 0;
        while (outValid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("satValid", {31'd0, outValid}, 32'd1);
        checkOutput("satCount", {22'd0, outCount}, 32'd1023);
        checkOutput("satSum", {5'd0, outSum}, 32'd0);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
